// File: rtl/lc3b_types.sv
// Shared LC-3b cache/memory types: line type plus the memory-arbiter state and
// side encodings.
package lc3b_types;

  typedef logic [127:0] lc3b_c_line;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    ARB_I,
    ARB_D
  } arb_side_t;

endpackage

// File: rtl/mem_arbiter_reg.sv
// Parameterized load-enabled register with asynchronous active-low clear.
module mem_arbiter_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one physical-memory line port between the
// instruction-fetch and data-side cache miss paths; all outputs registered.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int LINE_WIDTH  = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK =
    ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  arb_state_t state, state_nx;
  arb_side_t  last_grant, last_grant_nx;

  logic                  d_req;
  logic                  grant_i, grant_d;
  logic                  read_nx, write_nx;
  logic                  i_resp_nx, d_resp_nx;
  logic                  i_cap, d_cap;
  logic [ADDR_WIDTH-1:0] grant_addr;

  assign d_req      = d_read | d_write;
  assign grant_addr = (grant_d ? d_addr : i_addr) & ~OFFS_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ARB_I;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      pmem_read  <= read_nx;
      pmem_write <= write_nx;
      i_resp     <= i_resp_nx;
      d_resp     <= d_resp_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    read_nx       = pmem_read;
    write_nx      = pmem_write;
    i_resp_nx     = 1'b0;
    d_resp_nx     = 1'b0;
    i_cap         = 1'b0;
    d_cap         = 1'b0;

    case (state)
      IDLE: begin
        read_nx  = 1'b0;
        write_nx = 1'b0;
        // On a tie the side that did not win last time goes first.
        if (d_req && (!i_read || last_grant == ARB_I))
          grant_d = 1'b1;
        else if (i_read)
          grant_i = 1'b1;

        if (grant_d) begin
          state_nx      = SERVE_D;
          last_grant_nx = ARB_D;
          write_nx      = d_write;
          read_nx       = ~d_write;
        end else if (grant_i) begin
          state_nx      = SERVE_I;
          last_grant_nx = ARB_I;
          read_nx       = 1'b1;
        end
      end

      SERVE_I: begin
        if (pmem_resp) begin
          read_nx   = 1'b0;
          write_nx  = 1'b0;
          i_cap     = 1'b1;
          i_resp_nx = 1'b1;
          state_nx  = RESP_I;
        end
      end

      SERVE_D: begin
        if (pmem_resp) begin
          // Writes leave d_rdata untouched.
          d_cap     = pmem_read;
          read_nx   = 1'b0;
          write_nx  = 1'b0;
          d_resp_nx = 1'b1;
          state_nx  = RESP_D;
        end
      end

      RESP_I, RESP_D: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
        read_nx  = 1'b0;
        write_nx = 1'b0;
      end
    endcase
  end

  mem_arbiter_reg #(.WIDTH(ADDR_WIDTH)) u_addr_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (grant_i | grant_d),
    .d     (grant_addr),
    .q     (pmem_address)
  );

  mem_arbiter_reg #(.WIDTH(LINE_WIDTH)) u_wdata_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (grant_d),
    .d     (d_wdata),
    .q     (pmem_wdata)
  );

  mem_arbiter_reg #(.WIDTH(LINE_WIDTH)) u_i_rdata_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (i_cap),
    .d     (pmem_rdata),
    .q     (i_rdata)
  );

  mem_arbiter_reg #(.WIDTH(LINE_WIDTH)) u_d_rdata_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (d_cap),
    .d     (pmem_rdata),
    .q     (d_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model checks each grant against
// an expected queue, and a response monitor checks every resp pulse.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .OFFSET_BITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_addr       (i_addr),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            side_d;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            lat;
  } txn_t;

  txn_t          exp_q[$];
  txn_t          resp_q[$];
  int            total = 0;
  int            bad = 0;
  bit            mem_en = 1'b0;
  logic [LW-1:0] d_last = '0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic txn_t mk(input bit sd, input bit wr, input logic [AW-1:0] a,
                              input logic [LW-1:0] wd, input logic [LW-1:0] rd, input int lat);
    txn_t t;
    t.side_d = sd;
    t.wr     = wr;
    t.addr   = a;
    t.wdata  = wd;
    t.rdata  = rd;
    t.lat    = lat;
    return t;
  endfunction

  task automatic check_bus(input string name, input txn_t t);
    chk({name, "_read"},  LW'(pmem_read),  LW'(!t.wr));
    chk({name, "_write"}, LW'(pmem_write), LW'(t.wr));
    chk({name, "_addr"},  LW'(pmem_address), LW'(t.addr));
    if (t.wr)
      chk({name, "_wdata"}, pmem_wdata, t.wdata);
  endtask

  task automatic serve();
    txn_t cur;
    bit   have;
    have = (exp_q.size() != 0);
    total++;
    if (!have) begin
      bad++;
      $display("FAIL unexpected_grant: addr %h rd %0d wr %0d with nothing queued",
               pmem_address, pmem_read, pmem_write);
      cur = mk(1'b0, 1'b0, '0, '0, '0, 1);
    end else begin
      cur = exp_q.pop_front();
      check_bus("grant", cur);
    end
    for (int c = 0; c < cur.lat; c++) begin
      @(negedge clk);
      if (have) check_bus("hold", cur);
    end
    pmem_rdata = cur.rdata;
    if (have) resp_q.push_back(cur);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
  endtask

  // Memory model: answers each strobe after the queued latency.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_en && rst_n && (pmem_read || pmem_write))
        serve();
    end
  end

  // Response monitor.
  initial begin : resp_mon
    txn_t          r;
    logic [LW-1:0] want;
    forever begin
      @(negedge clk);
      total++;
      if (pmem_read && pmem_write) begin
        bad++;
        $display("FAIL two_strobes: pmem_read and pmem_write both high");
      end
      if (i_resp || d_resp) begin
        chk("resp_strobes_off", LW'({pmem_read, pmem_write}), '0);
        total++;
        if (i_resp && d_resp) begin
          bad++;
          $display("FAIL both_resp: i_resp and d_resp high together");
        end
        if (resp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: i_resp %0d d_resp %0d with nothing pending", i_resp, d_resp);
        end else begin
          r = resp_q.pop_front();
          chk("resp_side", LW'(d_resp), LW'(r.side_d));
          if (r.side_d) begin
            want = r.wr ? d_last : r.rdata;
            chk("d_rdata", d_rdata, want);
            if (!r.wr) d_last = r.rdata;
          end else begin
            chk("i_rdata", i_rdata, r.rdata);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_resp(input bit sd, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = sd ? d_resp : i_resp;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: no resp within 60 cycles", name);
    end
  endtask

  task automatic wait_strobe(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = pmem_read | pmem_write;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: no strobe within 60 cycles", name);
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_pmem_read"},  LW'(pmem_read), '0);
    chk({name, "_pmem_write"}, LW'(pmem_write), '0);
    chk({name, "_pmem_addr"},  LW'(pmem_address), '0);
    chk({name, "_pmem_wdata"}, pmem_wdata, '0);
    chk({name, "_i_resp"},     LW'(i_resp), '0);
    chk({name, "_d_resp"},     LW'(d_resp), '0);
    chk({name, "_i_rdata"},    i_rdata, '0);
    chk({name, "_d_rdata"},    d_rdata, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n   = 1'b0;
    i_read  = 1'b0;
    i_addr  = '0;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    tick(2);
    check_all_zero("por");
    @(negedge clk);
    rst_n  = 1'b1;
    mem_en = 1'b1;
    tick(2);
    chk("idle_no_strobe", LW'({pmem_read, pmem_write}), '0);

    // Single I read.
    exp_q.push_back(mk(1'b0, 1'b0, 16'h1230, '0,
                       128'hDEADBEEF_00000000_11111111_CAFEF00D, 4));
    i_addr = 16'h123A;
    i_read = 1'b1;
    wait_resp(1'b0, "i_single");
    i_read = 1'b0;
    tick(3);
    chk("i_rdata_holds", i_rdata, 128'hDEADBEEF_00000000_11111111_CAFEF00D);

    // D write.
    exp_q.push_back(mk(1'b1, 1'b1, 16'h4000, {16{8'hA5}}, '0, 3));
    d_addr  = 16'h4008;
    d_wdata = {16{8'hA5}};
    d_write = 1'b1;
    wait_resp(1'b1, "d_write");
    d_write = 1'b0;
    tick(2);

    // Asynchronous reset in the middle of a D write.
    mem_en  = 1'b0;
    d_addr  = 16'h4410;
    d_wdata = {16{8'h3C}};
    d_write = 1'b1;
    wait_strobe("rst_grant");
    chk("rst_pre_write", LW'(pmem_write), LW'(1'b1));
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    d_write = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    tick(4);
    chk("rst_no_strobe", LW'({pmem_read, pmem_write}), '0);
    chk("rst_no_d_resp", LW'(d_resp), '0);
    d_last = '0;
    mem_en = 1'b1;

    // Simultaneous requests right after reset: D first, then I.
    exp_q.push_back(mk(1'b1, 1'b0, 16'h2000, '0, {8{16'h2222}}, 2));
    exp_q.push_back(mk(1'b0, 1'b0, 16'h3000, '0, {8{16'h3333}}, 2));
    d_addr = 16'h2004;
    i_addr = 16'h300C;
    d_read = 1'b1;
    i_read = 1'b1;
    fork
      begin wait_resp(1'b1, "tie_d"); d_read = 1'b0; end
      begin wait_resp(1'b0, "tie_i"); i_read = 1'b0; end
    join
    tick(2);

    // Round-robin with both sides continuously requesting.
    for (int n = 0; n < 3; n++) begin
      exp_q.push_back(mk(1'b1, n == 1, 16'h8800 + 16'(n * 256), {8{16'hD000 + 16'(n)}},
                         {4{32'h8000_0000 + 32'(n)}}, 2));
      exp_q.push_back(mk(1'b0, 1'b0, 16'h5000 + 16'(n * 32), '0,
                         {4{32'h5000_0000 + 32'(n)}}, 2));
    end
    fork
      begin
        for (int n = 0; n < 3; n++) begin
          d_addr  = 16'h8804 + 16'(n * 256);
          d_wdata = {8{16'hD000 + 16'(n)}};
          d_write = (n == 1);
          d_read  = (n != 1);
          wait_resp(1'b1, "rr_d");
          d_read  = 1'b0;
          d_write = 1'b0;
          @(negedge clk);
        end
      end
      begin
        for (int n = 0; n < 3; n++) begin
          i_addr = 16'h5007 + 16'(n * 32);
          i_read = 1'b1;
          wait_resp(1'b0, "rr_i");
          i_read = 1'b0;
          @(negedge clk);
        end
      end
    join
    tick(2);

    // d_read and d_write together behave as a write.
    exp_q.push_back(mk(1'b1, 1'b1, 16'h7FF0, 128'h0123456789ABCDEF_FEDCBA9876543210, '0, 2));
    d_addr  = 16'h7FFF;
    d_wdata = 128'h0123456789ABCDEF_FEDCBA9876543210;
    d_read  = 1'b1;
    d_write = 1'b1;
    wait_resp(1'b1, "illegal_rw");
    d_read  = 1'b0;
    d_write = 1'b0;
    tick(2);

    // I request withdrawn during service still completes exactly once.
    exp_q.push_back(mk(1'b0, 1'b0, 16'h0AB0, '0, {4{32'h0BADCAFE}}, 3));
    i_addr = 16'h0ABC;
    i_read = 1'b1;
    wait_strobe("viol_grant");
    i_read = 1'b0;
    wait_resp(1'b0, "viol_resp");
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("viol_no_regrant", LW'({pmem_read, pmem_write}), '0);
    end

    chk("queues_drained", LW'(exp_q.size() + resp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction-fetch requester (IF stage / I-cache miss path) and the data requester (MEM stage / D-cache miss and writeback path).
- Sits between the split L1 caches and physical memory.
- Serializes transactions and latches the address and write data at grant.
- Returns one registered response pulse to the granted requester.

Parameters:
- ADDR_WIDTH, 16, byte address width
- LINE_WIDTH, 128, cache line width in bits
- OFFSET_BITS, 4, low address bits forced to zero on the memory side (log2 of line bytes)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- i_read  input  1  instruction-side line read request, level, held until i_resp
- i_addr  input  ADDR_WIDTH  instruction-side address
- i_rdata  output  LINE_WIDTH  instruction-side read data, valid when i_resp=1
- i_resp  output  1  one-cycle completion pulse to the instruction side
- d_read  input  1  data-side line read request, level
- d_write  input  1  data-side line write request, level
- d_addr  input  ADDR_WIDTH  data-side address
- d_wdata  input  LINE_WIDTH  data-side write line
- d_rdata  output  LINE_WIDTH  data-side read data, valid when d_resp=1
- d_resp  output  1  one-cycle completion pulse to the data side
- pmem_read  output  1  memory read strobe, level
- pmem_write  output  1  memory write strobe, level
- pmem_address  output  ADDR_WIDTH  line-aligned memory address
- pmem_wdata  output  LINE_WIDTH  memory write data
- pmem_rdata  input  LINE_WIDTH  memory read data, valid with pmem_resp
- pmem_resp  input  1  memory completion, single-cycle pulse

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, last_grant=I.
  - All strobes, resp pulses, pmem_address, pmem_wdata, i_rdata and d_rdata are 0.
  - Reset asserted mid-transaction abandons that transaction; no resp is issued afterwards.
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
- IDLE:
  - Evaluate d_req = d_read|d_write and i_read.
  - Only one requesting: grant it.
  - Both requesting: grant the side opposite last_grant (round-robin). After reset this gives D first on a tie.
  - On grant:
    - Latch pmem_address = addr with the low OFFSET_BITS cleared.
    - For D, latch pmem_wdata = d_wdata.
    - Set the strobe, update last_grant, and move to SERVE_x.
  - Strobe rules: I grant sets pmem_read. D grant sets pmem_write if d_write, else pmem_read. d_read and d_write together is illegal and is treated as a write.
- SERVE_x:
  - Strobe and latched address/data are held stable until pmem_resp.
  - New requests, and changes on the request inputs, are ignored.
  - On pmem_resp:
    - Deassert the strobe.
    - For a read, capture pmem_rdata into x_rdata.
    - Move to RESP_x.
- RESP_x:
  - x_resp=1 for exactly one cycle, with x_rdata stable in that cycle.
  - Next state is IDLE unconditionally.
  - Request inputs are not sampled in RESP_x. The requester drops or changes its request in the cycle after x_resp, so a stale level is never re-granted.
- x_rdata holds its last captured value until the next read completion for that side; it is not cleared.
- Latency:
  - Request sampled in IDLE at edge N → pmem strobe visible after edge N.
  - pmem_resp sampled at edge M → x_resp high for the cycle after edge M.
  - Minimum round trip is 3 cycles plus memory latency.
- A request withdrawn mid-SERVE is a protocol violation. The transaction still completes and resp still pulses.
- At most one pmem strobe is high at any time, and never in IDLE or RESP states.

Decomposition:
- lc3b_types gains:
  - lc3b_c_line, a 128-bit line type.
  - arb_state_t, an enum of the five states.
  - arb_side_t {ARB_I, ARB_D}, used for last_grant.
- Address and data latching reuse the existing parameterized register module, with load driven by the grant.
- No other sub-module.

Test Plan:
- Reset: rst_n=0 during SERVE_D with pmem_write=1 → all outputs 0 immediately (asynchronous), state IDLE. No d_resp after release even if pmem_resp arrives.
- Single I read:
  - i_read=1, i_addr=0x123A; memory responds after 4 cycles with rdata=0xDEADBEEF_00000000_11111111_CAFEF00D.
  - Required: pmem_read=1 and pmem_address=0x1230 until pmem_resp.
  - Then i_resp=1 for one cycle with i_rdata equal to that line; d_resp stays 0.
- D write:
  - d_write=1, d_addr=0x4008, d_wdata=0xA5…A5.
  - Required: pmem_write=1, pmem_address=0x4000, pmem_wdata stable throughout.
  - After pmem_resp, d_resp pulses once; d_rdata is unchanged.
- Simultaneous after reset: i_read and d_read both rise in the same cycle, both held → D served first, then I. Grant order is D, I; both resp pulses occur; no overlap of strobes.
- Round-robin fairness:
  - Hold both requests continuously, re-asserting after each resp, for 6 transactions.
  - Required: grants alternate D, I, D, I, D, I.
- Illegal and violation cases:
  - d_read=d_write=1 → treated as a write (pmem_write=1 only).
  - i_read dropped mid-SERVE_I → i_resp still pulses once; no second transaction starts.
